i2c_regfile_slave: RTL and testbench

Parametrised successor to the fixed LED/FND/switch I2C slaves. A single I2C target with a programmable 7-bit address and an N-byte register file, addressed through an internal pointer. Supports multi-byte burst writes and reads with pointer auto-increment and wrap, repeated START, and master NACK termination. Sits on the shared open-drain SCL/SDA bus beside the existing slaves inside i2c_system_top.

---
 rtl/i2c_regfile_slave.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_regfile_slave.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regfile_slave.sv
// I2C target with a programmable 7-bit address and an N-byte register file
// reached through an auto-incrementing, wrapping pointer (burst read/write, Sr).
module i2c_regfile_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h58,
    parameter int         NUM_REGS   = 4,
    parameter logic [7:0] RST_VAL    = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [NUM_REGS*8-1:0] regs_out,
    output logic                  wr_strobe,
    output logic [7:0]            wr_index,
    output logic                  addr_match,
    output logic                  busy,
    output logic [3:0]            debug_state
);
    localparam int         PW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] LAST = 8'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sclSync_q, sdaSync_q;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       phase_q, phase_d;
    logic       rw_q, rw_d;
    logic       sdaOe_q, sdaOe_d;
    logic       wrStrobe_q, wrStrobe_d;
    logic [7:0] wrIndex_q, wrIndex_d;
    logic       addrMatch_q, addrMatch_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];

    logic       sclNow, sclPrev, sdaNow, sdaPrev;
    logic       sclRise, sclFall, startDet, stopDet;
    logic [7:0] rxByte, curByte, ptrInc;

    // Bits [1:0] synchronise the pins; bit 2 is the delayed copy for edge detection.
    assign sclNow   = sclSync_q[1];
    assign sclPrev  = sclSync_q[2];
    assign sdaNow   = sdaSync_q[1];
    assign sdaPrev  = sdaSync_q[2];
    assign sclRise  = sclNow & ~sclPrev;
    assign sclFall  = ~sclNow & sclPrev;
    assign startDet = sclNow & sclPrev & sdaPrev & ~sdaNow;
    assign stopDet  = sclNow & sclPrev & ~sdaPrev & sdaNow;
    assign rxByte   = {shift_q[6:0], sdaNow};
    assign curByte  = regs_q[ptr_q[PW-1:0]];
    assign ptrInc   = (ptr_q == LAST) ? 8'd0 : ptr_q + 8'd1;

    // ACK states use phase_q: 0 = waiting for the fall ending bit 8, 1 = ACK clock in progress.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        phase_d     = phase_q;
        rw_d        = rw_q;
        sdaOe_d     = sdaOe_q;
        wrStrobe_d  = 1'b0;
        wrIndex_d   = wrIndex_q;
        addrMatch_d = 1'b0;
        regs_d      = regs_q;

        if (startDet) begin
            state_d = ADDR;
            cnt_d   = 3'd0;
            phase_d = 1'b0;
            sdaOe_d = 1'b0;
        end else if (stopDet) begin
            state_d = IDLE;
            phase_d = 1'b0;
            sdaOe_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR, PTR, WDATA: begin
                    if (sclRise) begin
                        shift_d = rxByte;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            state_d = IDLE;
                            if (state_q == ADDR) begin
                                if (rxByte[7:1] == SLAVE_ADDR) begin
                                    addrMatch_d = 1'b1;
                                    rw_d        = rxByte[0];
                                    state_d     = ADDR_ACK;
                                end
                            end else if (state_q == PTR) begin
                                if ({1'b0, rxByte} < 9'(NUM_REGS)) begin
                                    ptr_d   = rxByte;
                                    state_d = PTR_ACK;
                                end
                            end else begin
                                regs_d[ptr_q[PW-1:0]] = rxByte;
                                wrStrobe_d = 1'b1;
                                wrIndex_d  = ptr_q;
                                ptr_d      = ptrInc;
                                state_d    = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (sclFall) begin
                        if (!phase_q) begin
                            sdaOe_d = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = 3'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                shift_d = curByte;
                                sdaOe_d = ~curByte[7];
                                state_d = RDATA;
                            end else begin
                                sdaOe_d = 1'b0;
                                state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (sclRise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            state_d = RDATA_ACK;
                        end
                    end else if (sclFall && cnt_q != 3'd0) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        sdaOe_d = ~shift_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (sclFall) begin
                        if (!phase_q) begin
                            sdaOe_d = 1'b0;
                            phase_d = 1'b1;
                        end else begin
                            shift_d = curByte;
                            sdaOe_d = ~curByte[7];
                            cnt_d   = 3'd0;
                            phase_d = 1'b0;
                            state_d = RDATA;
                        end
                    end else if (sclRise && phase_q) begin
                        ptr_d = ptrInc;
                        if (sdaNow) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclSync_q   <= 3'b111;
            sdaSync_q   <= 3'b111;
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 8'd0;
            ptr_q       <= 8'd0;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            sdaOe_q     <= 1'b0;
            wrStrobe_q  <= 1'b0;
            wrIndex_q   <= 8'd0;
            addrMatch_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RST_VAL;
        end else begin
            sclSync_q   <= {sclSync_q[1:0], scl_i};
            sdaSync_q   <= {sdaSync_q[1:0], sda_i};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            phase_q     <= phase_d;
            rw_q        <= rw_d;
            sdaOe_q     <= sdaOe_d;
            wrStrobe_q  <= wrStrobe_d;
            wrIndex_q   <= wrIndex_d;
            addrMatch_q <= addrMatch_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign regs_out[8*k +: 8] = regs_q[k];
    end

    assign sda_oe      = sdaOe_q;
    assign wr_strobe   = wrStrobe_q;
    assign wr_index    = wrIndex_q;
    assign addr_match  = addrMatch_q;
    assign busy        = (state_q != IDLE) && (state_q != ADDR);
    assign debug_state = state_q;
endmodule

// File: tb/tb_i2c_regfile_slave.sv
// Bench for i2c_regfile_slave: a bit-banged I2C master drives the bus and a
// transaction-level register/pointer model supplies every expected value.
`timescale 1ns/1ps
module tb_i2c_regfile_slave;
    localparam logic [6:0] SLAVE = 7'h58;
    localparam int         NREGS = 4;
    localparam int         Q     = 80;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  sclMaster = 1'b1;
    logic                  sdaMaster = 1'b1;
    logic                  sda_oe;
    logic [NREGS*8-1:0]    regs_out;
    logic                  wr_strobe;
    logic [7:0]            wr_index;
    logic                  addr_match;
    logic                  busy;
    logic [3:0]            debug_state;
    wire                   sdaBus = sdaMaster & ~sda_oe;

    always #5 clk = ~clk;

    i2c_regfile_slave #(.SLAVE_ADDR(SLAVE), .NUM_REGS(NREGS), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .scl_i(sclMaster), .sda_i(sdaBus), .sda_oe(sda_oe),
        .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_index(wr_index),
        .addr_match(addr_match), .busy(busy), .debug_state(debug_state)
    );

    int         checks = 0;
    int         fails = 0;
    logic [7:0] strobeQ [$];
    int         matchCount = 0;
    int         oeCycles = 0;
    int         busyCycles = 0;
    logic [7:0] mRegs [NREGS];
    int         mPtr;

    // Cumulative record of pulse outputs; the test compares deltas across a transaction.
    always @(negedge clk) begin
        if (wr_strobe) strobeQ.push_back(wr_index);
        if (addr_match) matchCount++;
        if (sda_oe) oeCycles++;
        if (busy) busyCycles++;
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic busStart();
        sdaMaster = 1'b1; #Q; sclMaster = 1'b1; #Q; sdaMaster = 1'b0; #Q; sclMaster = 1'b0; #Q;
    endtask

    task automatic busStop();
        sdaMaster = 1'b0; #Q; sclMaster = 1'b1; #Q; sdaMaster = 1'b1; #Q;
    endtask

    task automatic writeBit(input logic b);
        sdaMaster = b; #Q; sclMaster = 1'b1; #(2*Q); sclMaster = 1'b0; #Q;
    endtask

    task automatic readBit(output logic b);
        sdaMaster = 1'b1; #Q; sclMaster = 1'b1; #Q; b = sdaBus; #Q; sclMaster = 1'b0; #Q;
    endtask

    task automatic writeByte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) writeBit(v[i]);
        readBit(b);
        ack = ~b;
    endtask

    task automatic readByte(input logic nack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) readBit(v[i]);
        writeBit(nack);
    endtask

    function automatic logic [31:0] modelFlat();
        logic [31:0] f;
        for (int k = 0; k < NREGS; k++) f[8*k +: 8] = mRegs[k];
        return f;
    endfunction

    // Write transaction: START, address+W, pointer byte, n data bytes, optional STOP.
    task automatic txWrite(input logic [6:0] addr, input logic [7:0] p, input int n,
                           input logic [31:0] data, input logic doStop);
        logic       ack, expAck;
        logic [7:0] expIdx [$];
        int         s0, m0;
        s0 = strobeQ.size();
        m0 = matchCount;
        busStart();
        writeByte({addr, 1'b0}, ack);
        expAck = (addr == SLAVE);
        checkOutput("write addr ack", 32'(ack), 32'(expAck));
        if (addr == SLAVE) begin
            writeByte(p, ack);
            expAck = (int'(p) < NREGS);
            checkOutput("pointer ack", 32'(ack), 32'(expAck));
            if (int'(p) < NREGS) begin
                mPtr = int'(p);
                for (int i = 0; i < n; i++) begin
                    writeByte(data[8*i +: 8], ack);
                    checkOutput("data ack", 32'(ack), 32'd1);
                    mRegs[mPtr[1:0]] = data[8*i +: 8];
                    expIdx.push_back(8'(mPtr));
                    mPtr = (mPtr + 1) % NREGS;
                end
            end
        end
        if (doStop) begin
            busStop();
            checkOutput("idle after stop", 32'(debug_state), 32'd0);
        end
        checkOutput("strobe count", 32'(strobeQ.size() - s0), 32'(expIdx.size()));
        for (int i = 0; i < expIdx.size() && s0 + i < strobeQ.size(); i++)
            checkOutput("strobe index", 32'(strobeQ[s0+i]), 32'(expIdx[i]));
        checkOutput("addr_match pulses", 32'(matchCount - m0), 32'(addr == SLAVE));
        checkOutput("regs after write", regs_out, modelFlat());
    endtask

    // Read transaction: START, address+R, n bytes (last one NACKed), optional STOP.
    task automatic txRead(input logic [6:0] addr, input int n, input logic doStop);
        logic       ack;
        logic [7:0] v;
        int         m0;
        m0 = matchCount;
        busStart();
        writeByte({addr, 1'b1}, ack);
        checkOutput("read addr ack", 32'(ack), 32'(addr == SLAVE));
        if (addr == SLAVE) begin
            for (int i = 0; i < n; i++) begin
                readByte(i == n - 1, v);
                checkOutput("read byte", 32'(v), 32'(mRegs[mPtr[1:0]]));
                mPtr = (mPtr + 1) % NREGS;
            end
        end
        if (doStop) begin
            busStop();
            checkOutput("idle after read", 32'(debug_state), 32'd0);
        end
        checkOutput("read addr_match", 32'(matchCount - m0), 32'(addr == SLAVE));
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  ptr;
        int          n;
        logic [31:0] data;
        logic        expAddrAck;
        logic        expPtrAck;
        logic [31:0] expRegs;
    } vec_t;

    vec_t vecs [8];

    task automatic applyStimulus(input vec_t v, output logic aAck, output logic pAck, output int dAcks);
        logic a;
        dAcks = 0;
        pAck  = 1'b0;
        busStart();
        writeByte({v.addr, 1'b0}, aAck);
        if (aAck) begin
            writeByte(v.ptr, pAck);
            if (pAck) begin
                for (int i = 0; i < v.n; i++) begin
                    writeByte(v.data[8*i +: 8], a);
                    dAcks += int'(a);
                end
            end
        end
        busStop();
    endtask

    initial begin
        logic       aAck, pAck, ack;
        int         dAcks, s0, m0, o0, b0, expN, kind, n;
        logic [6:0] rAddr;
        logic [7:0] rPtr;

        vecs[0] = '{SLAVE,  8'h00, 3, 32'h0033_2211, 1'b1, 1'b1, 32'h0033_2211};
        vecs[1] = '{SLAVE,  8'h03, 2, 32'h0000_BBAA, 1'b1, 1'b1, 32'hAA33_22BB};
        vecs[2] = '{SLAVE,  8'h07, 1, 32'h0000_00EE, 1'b1, 1'b0, 32'hAA33_22BB};
        vecs[3] = '{7'h55,  8'h00, 1, 32'h0000_00FF, 1'b0, 1'b0, 32'hAA33_22BB};
        vecs[4] = '{SLAVE,  8'h01, 1, 32'h0000_00C1, 1'b1, 1'b1, 32'hAA33_C1BB};
        vecs[5] = '{SLAVE,  8'h02, 4, 32'h0403_0201, 1'b1, 1'b1, 32'h0201_0403};
        vecs[6] = '{SLAVE,  8'h04, 1, 32'h0000_0055, 1'b1, 1'b0, 32'h0201_0403};
        vecs[7] = '{SLAVE,  8'h00, 0, 32'h0000_0000, 1'b1, 1'b1, 32'h0201_0403};

        repeat (5) @(negedge clk);
        checkOutput("reset sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("reset regs", regs_out, 32'd0);
        checkOutput("reset wr_strobe", 32'(wr_strobe), 32'd0);
        checkOutput("reset wr_index", 32'(wr_index), 32'd0);
        checkOutput("reset addr_match", 32'(addr_match), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset state", 32'(debug_state), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            s0 = strobeQ.size();
            m0 = matchCount;
            o0 = oeCycles;
            b0 = busyCycles;
            applyStimulus(vecs[i], aAck, pAck, dAcks);
            expN = (vecs[i].expAddrAck && vecs[i].expPtrAck) ? vecs[i].n : 0;
            checkOutput("vec addr ack", 32'(aAck), 32'(vecs[i].expAddrAck));
            checkOutput("vec ptr ack", 32'(pAck), 32'(vecs[i].expPtrAck));
            checkOutput("vec data acks", 32'(dAcks), 32'(expN));
            checkOutput("vec regs", regs_out, vecs[i].expRegs);
            checkOutput("vec strobe count", 32'(strobeQ.size() - s0), 32'(expN));
            for (int j = 0; j < expN && s0 + j < strobeQ.size(); j++)
                checkOutput("vec strobe index", 32'(strobeQ[s0+j]),
                            32'((int'(vecs[i].ptr) + j) % NREGS));
            checkOutput("vec addr_match", 32'(matchCount - m0), 32'(vecs[i].expAddrAck));
            checkOutput("vec sda pulled", 32'(oeCycles > o0), 32'(vecs[i].expAddrAck));
            checkOutput("vec busy seen", 32'(busyCycles > b0), 32'(vecs[i].expAddrAck));
            checkOutput("vec idle", 32'(debug_state), 32'd0);
        end

        for (int k = 0; k < NREGS; k++) mRegs[k] = vecs[7].expRegs[8*k +: 8];
        mPtr = 0;

        // Burst read with repeated START, then a 1-byte read proving the pointer wrapped.
        txWrite(SLAVE, 8'h00, 4, 32'h4433_2211, 1'b1);
        txWrite(SLAVE, 8'h01, 0, 32'h0, 1'b0);
        txRead(SLAVE, 3, 1'b1);
        txRead(SLAVE, 1, 1'b1);

        // STOP after four data bits must not commit anything.
        s0 = strobeQ.size();
        busStart();
        writeByte({SLAVE, 1'b0}, ack);
        checkOutput("abort addr ack", 32'(ack), 32'd1);
        writeByte(8'h02, ack);
        checkOutput("abort ptr ack", 32'(ack), 32'd1);
        mPtr = 2;
        for (int i = 0; i < 4; i++) writeBit(1'b0);
        busStop();
        checkOutput("abort strobe count", 32'(strobeQ.size() - s0), 32'd0);
        checkOutput("abort regs", regs_out, modelFlat());
        checkOutput("abort state", 32'(debug_state), 32'd0);

        // Reset while the slave is driving a read bit releases SDA asynchronously.
        txWrite(SLAVE, 8'h00, 0, 32'h0, 1'b0);
        busStart();
        writeByte({SLAVE, 1'b1}, ack);
        checkOutput("read addr ack before rst", 32'(ack), 32'd1);
        checkOutput("oe driving bit7 of 0x11", 32'(sda_oe), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst sda_oe immediate", 32'(sda_oe), 32'd0);
        checkOutput("rst regs immediate", regs_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        busStop();
        checkOutput("rst state", 32'(debug_state), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        for (int k = 0; k < NREGS; k++) mRegs[k] = 8'h00;
        mPtr = 0;

        // Randomised transactions against the model.
        for (int it = 0; it < 16; it++) begin
            kind  = $urandom_range(0, 3);
            rAddr = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : SLAVE;
            rPtr  = 8'($urandom_range(0, 5));
            n     = $urandom_range(1, 4);
            case (kind)
                0, 1: txWrite(rAddr, rPtr, $urandom_range(0, 4), $urandom(), 1'b1);
                2:    txRead(rAddr, n, 1'b1);
                default: begin
                    txWrite(SLAVE, rPtr, 0, 32'h0, 1'b0);
                    txRead(rAddr, n, 1'b1);
                end
            endcase
        end
        checkOutput("final regs", regs_out, modelFlat());

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
